soc_int_handler: RTL and testbench
==================================

// Module: soc_int_handler
// PURPOSE
//  Core-side end of SoC_InterruptBus (Handler modport): consumes pending-interrupt requests from the SoC
//  interrupt controller, decides at instruction boundaries whether to take them, acknowledges the taken ID,
//  redirects the core to a vectored handler, and restores the interrupted PC on return (mret).
//  Supports priority-based nesting up to NEST_DEPTH levels via an internal {PC, ID} stack.
// PARAMETERS
//  VECTOR_BASE  32'h0000_0100  handler table base; target = VECTOR_BASE + (id << 2)
//  NEST_DEPTH   4              max simultaneously in-service interrupts (1..8)
// PORTS
//  clk            in   1   system clock
//  res            in   1   synchronous active-high reset
//  int_pending    in   1   bus: controller has >=1 enabled, asserted interrupt
//  int_id         in   5   bus: lowest-index asserted interrupt (valid while int_pending)
//  int_ack        out  1   bus: 1-cycle pulse, acknowledges int_ack_id (controller clears that flag)
//  int_ack_id     out  5   bus: ID being acknowledged, valid with int_ack
//  int_enable     in   1   core global interrupt enable
//  core_boundary  in   1   core is at an instruction boundary, may be redirected this cycle
//  core_pc        in   32  PC of next instruction to execute (saved on take)
//  core_mret      in   1   core retiring return-from-interrupt this cycle
//  int_taken      out  1   1-cycle pulse: core must fetch from int_target
//  int_target     out  32  handler address, valid with int_taken
//  ret_valid      out  1   1-cycle pulse: core must fetch from ret_target
//  ret_target     out  32  saved PC, valid with ret_valid
//  in_service     out  1   stack depth > 0
//  active_id      out  5   ID at top of stack (0 when depth 0)
//  depth          out  4   current stack depth
//  spurious_mret  out  1   sticky: mret with empty stack; cleared only by res
// BEHAVIOUR
//  Reset: all outputs 0, depth 0, stack cleared, state IDLE; applies mid-operation (pending pulses dropped).
//  Take condition (sampled at posedge, state IDLE only): int_pending & int_enable & core_boundary
//   & depth<NEST_DEPTH & (depth==0 | int_id < active_id) & ~core_mret.
//  FSM: IDLE -> ACK on take; ACK -> SETTLE; SETTLE -> IDLE. No take evaluated in ACK or SETTLE
//   (one settle cycle lets the controller's cleared flag propagate to int_pending/int_id).
//  Take at edge N: during cycle N+1 (state ACK) int_taken=1, int_ack=1, int_ack_id=int_target id,
//   int_target=VECTOR_BASE+(id<<2) mod 2^32; {core_pc,int_id} pushed, depth+1, active_id=int_id.
//   All pulse outputs are registered, exactly one cycle wide.
//  mret (any state, sampled at posedge): depth>0 -> pop; next cycle ret_valid=1, ret_target=popped PC,
//   depth-1, active_id = new top ID (0 if empty). depth==0 -> no pop, ret_valid stays 0, spurious_mret<=1.
//  mret and a valid take in the same cycle: mret wins; take not performed (re-evaluated later if still pending).
//  mret during ACK/SETTLE: pop still performed; FSM sequence unaffected.
//  Equal or lower priority (int_id >= active_id) while in service: held pending, no ack, no take.
//  depth==NEST_DEPTH: no takes regardless of priority until a pop.
//  int_enable / core_boundary low: request stays pending, no side effects; int_pending drop is harmless.
// TESTING
//  1 Reset, int_pending=1,int_id=3,int_enable=1,core_boundary=1,core_pc=0x400 -> 1 cycle later int_taken=1,
//    int_ack=1,int_ack_id=3,int_target=0x10C; depth=1, active_id=3; no second take for 2 cycles.
//  2 In service id 3, raise id 1 at pc 0x520 -> take, target 0x104, depth 2; mret -> ret_target=0x520,
//    active_id=3; mret -> ret_target=0x400, depth 0, in_service=0.
//  3 In service id 3, request id 5 (and id 3) -> no ack/take until mret, then id 5 taken after pop.
//  4 Same-cycle core_mret and eligible take -> ret_valid only; take follows in a later cycle if still pending.
//  5 Fill to NEST_DEPTH=4 with ids 7,5,3,1, request id 0 -> not taken; mret -> id 0 taken next eligible cycle.
//  6 mret at depth 0 -> spurious_mret=1 sticky, ret_valid=0; res mid-ACK -> all outputs 0 next cycle.

Source files
------------

// File: rtl/soc_int_handler.sv
// soc_int_handler: core-side interrupt handler. Takes pending interrupts at
// instruction boundaries, acknowledges them, and redirects the core to a
// vectored handler. It keeps a {PC, ID} stack so that higher-priority
// interrupts can nest, and it restores the saved PC on mret.
module soc_int_handler #(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0100,
  parameter int          NEST_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        int_pending,
  input  logic [4:0]  int_id,
  output logic        int_ack,
  output logic [4:0]  int_ack_id,
  input  logic        int_enable,
  input  logic        core_boundary,
  input  logic [31:0] core_pc,
  input  logic        core_mret,
  output logic        int_taken,
  output logic [31:0] int_target,
  output logic        ret_valid,
  output logic [31:0] ret_target,
  output logic        in_service,
  output logic [4:0]  active_id,
  output logic [3:0]  depth,
  output logic        spurious_mret
);

  // The stack storage always has 8 slots, so a 3-bit index addresses it
  // exactly. Only the first NEST_DEPTH slots are ever written.
  localparam int          STACK_SLOTS = 8;
  localparam logic [3:0]  MAX_DEPTH   = 4'(NEST_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  depth_reg;
  logic [4:0]  active_id_reg;
  logic        int_taken_reg;
  logic        int_ack_reg;
  logic [4:0]  int_ack_id_reg;
  logic [31:0] int_target_reg;
  logic        ret_valid_reg;
  logic [31:0] ret_target_reg;
  logic        spurious_mret_reg;

  logic [31:0] pc_stack_reg [STACK_SLOTS];
  logic [4:0]  id_stack_reg [STACK_SLOTS];

  logic        do_take;
  logic        do_pop;
  logic        do_spurious;
  logic [2:0]  push_idx;
  logic [2:0]  pop_idx;
  logic [2:0]  top_after_pop_idx;
  logic [31:0] vector_target;

  // mret has priority over a take. The take is blocked rather than
  // deferred, so it is simply evaluated again in a later cycle.
  assign do_take = (state_reg == IDLE) && int_pending && int_enable && core_boundary
                   && (depth_reg < MAX_DEPTH)
                   && ((depth_reg == 4'd0) || (int_id < active_id_reg))
                   && !core_mret;
  assign do_pop      = core_mret && (depth_reg != 4'd0);
  assign do_spurious = core_mret && (depth_reg == 4'd0);

  assign push_idx          = depth_reg[2:0];
  assign pop_idx           = depth_reg[2:0] - 3'd1;
  assign top_after_pop_idx = depth_reg[2:0] - 3'd2;
  assign vector_target     = VECTOR_BASE + {25'd0, int_id, 2'b00};

  genvar gi;
  generate
    for (gi = 0; gi < STACK_SLOTS; gi++) begin : g_stack
      // Each stack slot captures {PC, ID} when a take pushes into this slot.
      always_ff @(posedge clk) begin
        if (res) begin
          pc_stack_reg[gi] <= '0;
          id_stack_reg[gi] <= '0;
        end else if (do_take && (push_idx == 3'(gi))) begin
          pc_stack_reg[gi] <= core_pc;
          id_stack_reg[gi] <= int_id;
        end
      end
    end
  endgenerate

  // Sequencer: take/ack FSM, stack depth and top ID, registered pulse outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_reg         <= IDLE;
      depth_reg         <= '0;
      active_id_reg     <= '0;
      int_taken_reg     <= 1'b0;
      int_ack_reg       <= 1'b0;
      int_ack_id_reg    <= '0;
      int_target_reg    <= '0;
      ret_valid_reg     <= 1'b0;
      ret_target_reg    <= '0;
      spurious_mret_reg <= 1'b0;
    end else begin
      int_taken_reg  <= do_take;
      int_ack_reg    <= do_take;
      int_ack_id_reg <= do_take ? int_id : 5'd0;
      int_target_reg <= do_take ? vector_target : 32'd0;
      ret_valid_reg  <= do_pop;
      ret_target_reg <= do_pop ? pc_stack_reg[pop_idx] : 32'd0;
      if (do_spurious) begin
        spurious_mret_reg <= 1'b1;
      end

      // ACK and SETTLE give the controller time to clear the acknowledged
      // flag before int_pending/int_id are trusted again.
      case (state_reg)
        IDLE:    if (do_take) state_reg <= ACK;
        ACK:     state_reg <= SETTLE;
        SETTLE:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      // A push and a pop can never happen in the same cycle, because mret
      // blocks the take.
      if (do_take) begin
        depth_reg     <= depth_reg + 4'd1;
        active_id_reg <= int_id;
      end else if (do_pop) begin
        depth_reg     <= depth_reg - 4'd1;
        active_id_reg <= (depth_reg == 4'd1) ? 5'd0 : id_stack_reg[top_after_pop_idx];
      end
    end
  end

  assign int_taken     = int_taken_reg;
  assign int_ack       = int_ack_reg;
  assign int_ack_id    = int_ack_id_reg;
  assign int_target    = int_target_reg;
  assign ret_valid     = ret_valid_reg;
  assign ret_target    = ret_target_reg;
  assign in_service    = (depth_reg != 4'd0);
  assign active_id     = active_id_reg;
  assign depth         = depth_reg;
  assign spurious_mret = spurious_mret_reg;

endmodule

// File: tb/tb_soc_int_handler.sv
// tb_soc_int_handler: directed checks of soc_int_handler. It covers take,
// nesting, blocked priority, mret precedence, a full stack, spurious mret,
// and reset in the middle of an operation.
module tb_soc_int_handler;

  logic        clk;
  logic        res;
  logic        int_pending;
  logic [4:0]  int_id;
  logic        int_ack;
  logic [4:0]  int_ack_id;
  logic        int_enable;
  logic        core_boundary;
  logic [31:0] core_pc;
  logic        core_mret;
  logic        int_taken;
  logic [31:0] int_target;
  logic        ret_valid;
  logic [31:0] ret_target;
  logic        in_service;
  logic [4:0]  active_id;
  logic [3:0]  depth;
  logic        spurious_mret;

  int n_cmp;
  int n_err;

  soc_int_handler #(
    .VECTOR_BASE(32'h0000_0100),
    .NEST_DEPTH (4)
  ) dut (
    .clk          (clk),
    .res          (res),
    .int_pending  (int_pending),
    .int_id       (int_id),
    .int_ack      (int_ack),
    .int_ack_id   (int_ack_id),
    .int_enable   (int_enable),
    .core_boundary(core_boundary),
    .core_pc      (core_pc),
    .core_mret    (core_mret),
    .int_taken    (int_taken),
    .int_target   (int_target),
    .ret_valid    (ret_valid),
    .ret_target   (ret_target),
    .in_service   (in_service),
    .active_id    (active_id),
    .depth        (depth),
    .spurious_mret(spurious_mret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Check the outputs registered by a take.
  task automatic check_take(input string tag, input logic [4:0] id, input logic [3:0] d);
    check({tag, "_taken"},  {31'd0, int_taken}, 32'd1);
    check({tag, "_ack"},    {31'd0, int_ack}, 32'd1);
    check({tag, "_ack_id"}, {27'd0, int_ack_id}, {27'd0, id});
    check({tag, "_target"}, int_target, 32'h100 + {25'd0, id, 2'b00});
    check({tag, "_depth"},  {28'd0, depth}, {28'd0, d});
    check({tag, "_active"}, {27'd0, active_id}, {27'd0, id});
  endtask

  // Present a request, check the take, then drop it and let the FSM return to IDLE.
  task automatic take_one(input string tag, input logic [4:0] id, input logic [31:0] pc,
                          input logic [3:0] d);
    int_pending = 1'b1;
    int_id      = id;
    core_pc     = pc;
    tick();
    check_take(tag, id, d);
    int_pending = 1'b0;
    tick();
    tick();
  endtask

  // Pulse mret for one cycle and check the pop result.
  task automatic mret_one(input string tag, input logic [31:0] pc, input logic [3:0] d,
                          input logic [4:0] act);
    core_mret = 1'b1;
    tick();
    core_mret = 1'b0;
    check({tag, "_ret_valid"},  {31'd0, ret_valid}, 32'd1);
    check({tag, "_ret_target"}, ret_target, pc);
    check({tag, "_depth"},      {28'd0, depth}, {28'd0, d});
    check({tag, "_active"},     {27'd0, active_id}, {27'd0, act});
    $display("mret %s: ret_target=%0h depth=%0d active_id=%0d", tag, ret_target, depth, active_id);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    res = 1'b1;
    int_pending = 1'b0;
    int_id = 5'd0;
    int_enable = 1'b0;
    core_boundary = 1'b0;
    core_pc = 32'd0;
    core_mret = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_taken",    {31'd0, int_taken}, 32'd0);
    check("rst_ack",      {31'd0, int_ack}, 32'd0);
    check("rst_depth",    {28'd0, depth}, 32'd0);
    check("rst_inserv",   {31'd0, in_service}, 32'd0);
    check("rst_spurious", {31'd0, spurious_mret}, 32'd0);
    $display("reset: depth=%0d in_service=%0d", depth, in_service);

    // 1: first take, id 3 at pc 0x400
    res = 1'b0;
    int_pending = 1'b1;
    int_id = 5'd3;
    int_enable = 1'b1;
    core_boundary = 1'b1;
    core_pc = 32'h400;
    tick();
    check_take("t1", 5'd3, 4'd1);
    check("t1_inserv", {31'd0, in_service}, 32'd1);
    $display("take t1: id=%0d target=%0h depth=%0d", int_ack_id, int_target, depth);

    // 2: id 1 becomes pending during ACK. It is not taken in ACK or SETTLE,
    // and it is taken once the FSM is back in IDLE.
    int_id = 5'd1;
    core_pc = 32'h520;
    tick();
    check("t1_ack_no_take", {31'd0, int_taken}, 32'd0);
    check("t1_ack_no_ack",  {31'd0, int_ack}, 32'd0);
    tick();
    check("t1_settle_no_take", {31'd0, int_taken}, 32'd0);
    check("t1_settle_depth",   {28'd0, depth}, 32'd1);
    tick();
    check_take("t2_nest", 5'd1, 4'd2);
    $display("take t2: id=%0d target=%0h depth=%0d", int_ack_id, int_target, depth);
    int_pending = 1'b0;
    tick();
    tick();
    mret_one("t2_pop1", 32'h520, 4'd1, 5'd3);
    mret_one("t2_pop2", 32'h400, 4'd0, 5'd0);
    check("t2_inserv", {31'd0, in_service}, 32'd0);

    // 3: lower and equal priority requests are held while id 3 is in service.
    take_one("t3_take3", 5'd3, 32'h600, 4'd1);
    int_pending = 1'b1;
    int_id = 5'd3;
    tick();
    check("t3_eq_no_take", {31'd0, int_taken}, 32'd0);
    int_id = 5'd5;
    core_pc = 32'h700;
    tick();
    check("t3_lo_no_take", {31'd0, int_taken}, 32'd0);
    tick();
    check("t3_lo_no_ack", {31'd0, int_ack}, 32'd0);
    core_mret = 1'b1;
    tick();
    core_mret = 1'b0;
    check("t3_pop_ret",      ret_target, 32'h600);
    check("t3_pop_no_take",  {31'd0, int_taken}, 32'd0);
    check("t3_pop_depth",    {28'd0, depth}, 32'd0);
    tick();
    check_take("t3_take5", 5'd5, 4'd1);
    $display("take t3: id=%0d target=%0h depth=%0d", int_ack_id, int_target, depth);
    int_pending = 1'b0;
    tick();
    tick();

    // 4: mret in the same cycle as an eligible take. mret wins, and the
    // take follows in the next cycle.
    int_pending = 1'b1;
    int_id = 5'd2;
    core_pc = 32'h800;
    core_mret = 1'b1;
    tick();
    core_mret = 1'b0;
    check("t4_ret_valid", {31'd0, ret_valid}, 32'd1);
    check("t4_ret_target", ret_target, 32'h700);
    check("t4_no_take",   {31'd0, int_taken}, 32'd0);
    check("t4_no_ack",    {31'd0, int_ack}, 32'd0);
    tick();
    check_take("t4_take2", 5'd2, 4'd1);
    check("t4_ret_clear", {31'd0, ret_valid}, 32'd0);
    $display("take t4: id=%0d target=%0h depth=%0d", int_ack_id, int_target, depth);
    int_pending = 1'b0;
    tick();
    tick();
    mret_one("t4_pop", 32'h800, 4'd0, 5'd0);

    // 5: fill the stack to NEST_DEPTH. Id 0 is then blocked until a pop.
    take_one("t5_f7", 5'd7, 32'h1000, 4'd1);
    take_one("t5_f5", 5'd5, 32'h1004, 4'd2);
    take_one("t5_f3", 5'd3, 32'h1008, 4'd3);
    take_one("t5_f1", 5'd1, 32'h100C, 4'd4);
    int_pending = 1'b1;
    int_id = 5'd0;
    core_pc = 32'h2000;
    tick();
    check("t5_full_no_take", {31'd0, int_taken}, 32'd0);
    tick();
    check("t5_full_depth",   {28'd0, depth}, 32'd4);
    core_mret = 1'b1;
    tick();
    core_mret = 1'b0;
    check("t5_pop_ret",     ret_target, 32'h100C);
    check("t5_pop_no_take", {31'd0, int_taken}, 32'd0);
    check("t5_pop_active",  {27'd0, active_id}, 32'd3);
    tick();
    check_take("t5_take0", 5'd0, 4'd4);
    $display("take t5: id=%0d target=%0h depth=%0d", int_ack_id, int_target, depth);
    int_pending = 1'b0;
    tick();
    tick();
    mret_one("t5_u1", 32'h2000, 4'd3, 5'd3);
    mret_one("t5_u2", 32'h1008, 4'd2, 5'd5);
    mret_one("t5_u3", 32'h1004, 4'd1, 5'd7);
    mret_one("t5_u4", 32'h1000, 4'd0, 5'd0);

    // A request with enable low or with the core not at a boundary has no effect.
    int_pending = 1'b1;
    int_id = 5'd2;
    int_enable = 1'b0;
    tick();
    check("en_low_no_take", {31'd0, int_taken}, 32'd0);
    int_enable = 1'b1;
    core_boundary = 1'b0;
    tick();
    check("bnd_low_no_take", {31'd0, int_taken}, 32'd0);
    check("bnd_low_depth",   {28'd0, depth}, 32'd0);
    int_pending = 1'b0;
    core_boundary = 1'b1;

    // 6: spurious mret is sticky, and a reset during ACK clears everything.
    core_mret = 1'b1;
    tick();
    core_mret = 1'b0;
    check("t6_spur",         {31'd0, spurious_mret}, 32'd1);
    check("t6_spur_no_ret",  {31'd0, ret_valid}, 32'd0);
    check("t6_spur_depth",   {28'd0, depth}, 32'd0);
    tick();
    check("t6_spur_sticky",  {31'd0, spurious_mret}, 32'd1);
    $display("spurious mret: spurious_mret=%0d", spurious_mret);
    int_pending = 1'b1;
    int_id = 5'd4;
    core_pc = 32'h300;
    tick();
    check_take("t6_take4", 5'd4, 4'd1);
    res = 1'b1;
    int_pending = 1'b0;
    tick();
    res = 1'b0;
    check("t6_rst_taken",  {31'd0, int_taken}, 32'd0);
    check("t6_rst_ack",    {31'd0, int_ack}, 32'd0);
    check("t6_rst_ack_id", {27'd0, int_ack_id}, 32'd0);
    check("t6_rst_target", int_target, 32'd0);
    check("t6_rst_depth",  {28'd0, depth}, 32'd0);
    check("t6_rst_active", {27'd0, active_id}, 32'd0);
    check("t6_rst_inserv", {31'd0, in_service}, 32'd0);
    check("t6_rst_spur",   {31'd0, spurious_mret}, 32'd0);
    $display("reset mid-ACK: depth=%0d spurious_mret=%0d", depth, spurious_mret);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
